// File: rtl/jtframe_dwnld_pkg.sv
// Shared types for the ROM download path: bank map, byte-lane masks, FIFO entry.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package jtframe_dwnld_pkg;

    // Default first byte address of each SDRAM bank in the download stream
    localparam logic [24:0] BA1_START_DEF = 25'h10_0000;
    localparam logic [24:0] BA2_START_DEF = 25'h20_0000;
    localparam logic [24:0] BA3_START_DEF = 25'h30_0000;

    // Word-address width carried through the FIFO
    localparam int PROG_AW = 23;

    // Byte masks, active low: bit 0 guards the low byte
    localparam logic [1:0] MASK_LO = 2'b10;  // even byte only
    localparam logic [1:0] MASK_HI = 2'b01;  // odd byte only
    localparam logic [1:0] MASK_W  = 2'b00;  // full 16-bit word

    // One queued SDRAM write
    typedef struct packed {
        logic [1:0]         ba;
        logic [PROG_AW-1:0] addr;
        logic [15:0]        data;
        logic [1:0]         mask;
    } prog_entry_t;

    // Where a single download byte lands
    typedef struct packed {
        logic [1:0]         ba;
        logic [PROG_AW-1:0] word;
        logic               lane;
    } byte_loc_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } prog_st_t;

    // Bank select by threshold, then offset within the bank split into word/lane
    function automatic byte_loc_t map_byte(
        input logic [24:0] addr,
        input logic [24:0] ba1_start,
        input logic [24:0] ba2_start,
        input logic [24:0] ba3_start
    );
        byte_loc_t        loc;
        logic [24:0]      start;
        logic [PROG_AW:0] off;
        if (addr >= ba3_start) begin
            loc.ba = 2'd3;
            start  = ba3_start;
        end else if (addr >= ba2_start) begin
            loc.ba = 2'd2;
            start  = ba2_start;
        end else if (addr >= ba1_start) begin
            loc.ba = 2'd1;
            start  = ba1_start;
        end else begin
            loc.ba = 2'd0;
            start  = '0;
        end
        off      = (PROG_AW+1)'(addr - start);
        loc.word = off[PROG_AW:1];
        loc.lane = off[0];
        return loc;
    endfunction

endpackage

// File: rtl/jtframe_ioctl_fifo.sv
// Single-clock FIFO with registered storage and show-ahead read data.
// Latency: a push is visible at pop_dat (empty=0) the cycle after the push.
// Backpressure: push while full is ignored (caller detects via full); pop while empty is ignored.
module jtframe_ioctl_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    input  logic          pop_rdy,
    output logic [DW-1:0] pop_dat,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 2**AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit tells full from empty when the indices coincide
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push_vld && !full;
    assign do_pop  = pop_rdy && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset discards any queued entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone decide what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/jtframe_ioctl_pack.sv
// Packs the loader byte stream into banked 16-bit SDRAM writes and drives prog_*.
// Latency: FIFO push in cycle N raises prog_we in cycle N+1 when idle (pair: 2 cycles after odd byte).
// Backpressure: none toward the loader; a full FIFO drops the entry and sets sticky overflow.
module jtframe_ioctl_pack
    import jtframe_dwnld_pkg::*;
#(
    parameter int          SDRAMW    = 23,
    parameter logic [24:0] BA1_START = BA1_START_DEF,
    parameter logic [24:0] BA2_START = BA2_START_DEF,
    parameter logic [24:0] BA3_START = BA3_START_DEF,
    parameter int          FIFO_AW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              downloading,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              ioctl_wr,
    output logic [SDRAMW-1:0] prog_addr,
    output logic [15:0]       prog_data,
    output logic [1:0]        prog_mask,
    output logic [1:0]        prog_ba,
    output logic              prog_we,
    input  logic              prog_rdy,
    output logic              dwnld_busy,
    output logic              overflow
);

    // Download window edges
    logic dl_q;
    logic dl_rise;
    logic dl_fall;

    // Pending even byte waiting for its odd partner
    logic               hold_vld;
    logic [1:0]         hold_ba;
    logic [PROG_AW-1:0] hold_word;
    logic [7:0]         hold_byte;

    byte_loc_t   loc;
    prog_entry_t held_entry;
    prog_entry_t push_dat;
    prog_entry_t pop_dat;
    logic        push_vld;
    logic        hold_load;
    logic        hold_clr;
    logic        same_word;

    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;

    prog_st_t    st;
    logic        busy_q;
    logic        all_idle;

    assign dl_rise = downloading && !dl_q;
    assign dl_fall = !downloading && dl_q;

    // Remember last downloading level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dl_q <= 1'b0;
        else     dl_q <= downloading;
    end

    // Locate the incoming byte and decide what, if anything, goes into the FIFO
    always_comb begin
        loc = map_byte(ioctl_addr, BA1_START, BA2_START, BA3_START);

        held_entry.ba   = hold_ba;
        held_entry.addr = hold_word;
        held_entry.data = {hold_byte, hold_byte};
        held_entry.mask = MASK_LO;

        same_word = hold_vld && (hold_ba == loc.ba) && (hold_word == loc.word);

        push_vld  = 1'b0;
        push_dat  = held_entry;
        hold_load = 1'b0;
        hold_clr  = 1'b0;

        if (ioctl_wr) begin
            if (loc.lane) begin
                // Odd byte always produces exactly one push and empties the hold
                push_vld = 1'b1;
                hold_clr = hold_vld;
                if (same_word) begin
                    push_dat.data = {ioctl_dout, hold_byte};
                    push_dat.mask = MASK_W;
                end else if (!hold_vld) begin
                    push_dat.ba   = loc.ba;
                    push_dat.addr = loc.word;
                    push_dat.data = {ioctl_dout, ioctl_dout};
                    push_dat.mask = MASK_HI;
                end
                // held but unrelated: the stale even byte goes out, the odd one is lost
            end else begin
                // Even byte displaces any older pending byte
                push_vld  = hold_vld;
                hold_load = 1'b1;
            end
        end else if (dl_fall && hold_vld) begin
            // End of download: an unpaired even byte is written alone
            push_vld = 1'b1;
            hold_clr = 1'b1;
        end
    end

    // Hold register for the pending even byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_vld  <= 1'b0;
            hold_ba   <= '0;
            hold_word <= '0;
            hold_byte <= '0;
        end else if (hold_load) begin
            hold_vld  <= 1'b1;
            hold_ba   <= loc.ba;
            hold_word <= loc.word;
            hold_byte <= ioctl_dout;
        end else if (hold_clr) begin
            hold_vld  <= 1'b0;
        end
    end

    // Sticky drop flag, rearmed at the start of each download
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       overflow <= 1'b0;
        else if (push_vld && fifo_full) overflow <= 1'b1;
        else if (dl_rise)              overflow <= 1'b0;
    end

    assign fifo_pop = (st == ST_IDLE) && !fifo_empty;

    jtframe_ioctl_fifo #(
        .DW ($bits(prog_entry_t)),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_rdy  (fifo_pop),
        .pop_dat  (pop_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // SDRAM request FSM: one outstanding write, outputs frozen until prog_rdy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= ST_IDLE;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= '0;
            prog_ba   <= '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        prog_addr <= SDRAMW'(pop_dat.addr);
                        prog_data <= pop_dat.data;
                        prog_mask <= pop_dat.mask;
                        prog_ba   <= pop_dat.ba;
                        prog_we   <= 1'b1;
                        st        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Returning through IDLE guarantees a gap cycle between requests
                    if (prog_rdy) begin
                        prog_we <= 1'b0;
                        st      <= ST_IDLE;
                    end
                end
                default: begin
                    prog_we <= 1'b0;
                    st      <= ST_IDLE;
                end
            endcase
        end
    end

    // Nothing left anywhere in the write path and the loader has finished
    assign all_idle = !downloading && !hold_vld && fifo_empty && (st == ST_IDLE);

    // Busy is set by the download start and released once everything has drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           busy_q <= 1'b0;
        else if (dl_rise)  busy_q <= 1'b1;
        else if (all_idle) busy_q <= 1'b0;
    end

    // Drop busy in the very cycle the path becomes idle
    assign dwnld_busy = busy_q && !all_idle;

endmodule

// File: tb/tb_jtframe_ioctl_pack.sv
// Directed bench for jtframe_ioctl_pack with a write scoreboard and prog_rdy responder.
// Latency: checks prog_we rises two cycles after the odd byte of a pair.
// Backpressure: prog_rdy can be withheld to fill the FIFO and force overflow.
module tb_jtframe_ioctl_pack;

    typedef struct {
        logic [1:0]  ba;
        logic [22:0] addr;
        logic [15:0] data;
        logic [1:0]  mask;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        downloading = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wr = 1'b0;
    logic        prog_rdy = 1'b0;
    logic [22:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic [1:0]  prog_ba;
    logic        prog_we;
    logic        dwnld_busy;
    logic        overflow;

    int   checks = 0;
    int   failures = 0;
    int   wr_idx = 0;
    exp_t exp_q[$];
    logic rdy_en = 1'b1;

    // Loader-side view of the pending even byte, used only for the contract assertion
    logic        hold_vld_m = 1'b0;
    logic [24:0] hold_addr_m = '0;

    always #5 clk = ~clk;

    jtframe_ioctl_pack dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_ba     (prog_ba),
        .prog_we     (prog_we),
        .prog_rdy    (prog_rdy),
        .dwnld_busy  (dwnld_busy),
        .overflow    (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_write(input logic [1:0] ba, input logic [22:0] addr,
                                input logic [15:0] data, input logic [1:0] mask);
        exp_t e;
        e.ba = ba; e.addr = addr; e.data = data; e.mask = mask;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [24:0] addr, input logic [7:0] data);
        @(negedge clk);
        if (addr[0]) begin
            assert (!hold_vld_m || hold_addr_m == addr - 25'd1)
                else $error("loader contract broken: odd byte at %0h after pending even byte at %0h",
                            addr, hold_addr_m);
            hold_vld_m = 1'b0;
        end else begin
            hold_vld_m  = 1'b1;
            hold_addr_m = addr;
        end
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
    endtask

    task automatic set_dl(input logic v);
        @(negedge clk);
        downloading = v;
        if (!v) hold_vld_m = 1'b0;
    endtask

    // Wait until all expected writes were seen and the request line is low (optionally busy low)
    task automatic wait_idle(input string name, input int budget, input bit need_busy_low);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !prog_we && (!need_busy_low || !dwnld_busy)) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout after %0d cycles: pending=%0d prog_we=%0b busy=%0b required drained",
                     name, budget, exp_q.size(), prog_we, dwnld_busy);
        end
    endtask

    // Memory-controller model: acknowledges each request three cycles after it appears
    initial begin : responder
        forever begin
            @(negedge clk);
            if (rdy_en && prog_we && !rst) begin
                repeat (2) @(negedge clk);
                prog_rdy = 1'b1;
                @(negedge clk);
                prog_rdy = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every new request is compared against the oldest expectation
    initial begin : monitor
        logic we_q;
        exp_t e;
        we_q = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (prog_we && !we_q) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write actual ba=%0d addr=%0h data=%0h mask=%b required no write",
                             prog_ba, prog_addr, prog_data, prog_mask);
                end else begin
                    e = exp_q.pop_front();
                    if (prog_ba !== e.ba || prog_addr !== e.addr || prog_data !== e.data || prog_mask !== e.mask) begin
                        failures++;
                        $display("FAIL write_%0d actual ba=%0d addr=%0h data=%0h mask=%b required ba=%0d addr=%0h data=%0h mask=%b",
                                 wr_idx, prog_ba, prog_addr, prog_data, prog_mask, e.ba, e.addr, e.data, e.mask);
                    end
                end
                wr_idx++;
            end
            we_q = prog_we;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic prev_busy;
        bit   found;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_prog_we",   prog_we,    0);
        check("rst_busy",      dwnld_busy, 0);
        check("rst_overflow",  overflow,   0);
        check("rst_prog_addr", prog_addr,  0);
        check("rst_prog_data", prog_data,  0);
        check("rst_prog_mask", prog_mask,  0);
        check("rst_prog_ba",   prog_ba,    0);
        @(negedge clk);
        rst = 1'b0;

        // Even/odd pair merges into one word; prog_we two cycles after the odd byte
        set_dl(1'b1);
        @(posedge clk);
        #1;
        check("busy_set", dwnld_busy, 1);
        expect_write(2'd0, 23'h0, 16'h3412, 2'b00);
        send_byte(25'h0, 8'h12);
        send_byte(25'h1, 8'h34);
        check("lat_cycle1_we", prog_we, 0);
        @(posedge clk);
        #1;
        check("lat_cycle2_we", prog_we, 1);
        wait_idle("t1_drain", 40, 1'b0);

        // Lone odd byte, then end of download; busy falls right after the acknowledge
        expect_write(2'd0, 23'h2, 16'hAAAA, 2'b01);
        send_byte(25'h5, 8'hAA);
        set_dl(1'b0);
        prev_busy = dwnld_busy;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (prog_rdy) found = 1'b1;
            else          prev_busy = dwnld_busy;
        end
        check("t2_rdy_seen", found, 1);
        check("t2_busy_before_rdy", prev_busy, 1);
        check("t2_busy_after_rdy", dwnld_busy, 0);
        wait_idle("t2_drain", 40, 1'b1);

        // Bank 0 / bank 1 boundary, last even byte flushed at window end
        set_dl(1'b1);
        expect_write(2'd0, 23'h7FFFF, 16'h2211, 2'b00);
        expect_write(2'd1, 23'h0,     16'h3333, 2'b10);
        send_byte(25'h0F_FFFE, 8'h11);
        send_byte(25'h0F_FFFF, 8'h22);
        send_byte(25'h10_0000, 8'h33);
        set_dl(1'b0);
        wait_idle("t3_drain", 60, 1'b1);

        // Overflow: one write stalled in flight, four queued, two dropped
        set_dl(1'b1);
        rdy_en = 1'b0;
        expect_write(2'd0, 23'h80,  16'hA1A0, 2'b00);
        expect_write(2'd0, 23'h100, 16'h4140, 2'b00);
        expect_write(2'd0, 23'h101, 16'h4342, 2'b00);
        expect_write(2'd0, 23'h102, 16'h4544, 2'b00);
        expect_write(2'd0, 23'h103, 16'h4746, 2'b00);
        send_byte(25'h100, 8'hA0);
        send_byte(25'h101, 8'hA1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 12; i++) send_byte(25'h200 + 25'(i), 8'h40 + 8'(i));
        @(posedge clk);
        #1;
        check("t4_ovf_set", overflow, 1);
        check("t4_stalled_we", prog_we, 1);
        rdy_en = 1'b1;
        wait_idle("t4_drain", 120, 1'b0);
        check("t4_ovf_sticky", overflow, 1);
        set_dl(1'b0);
        @(posedge clk);
        #1;
        check("t4_ovf_after_fall", overflow, 1);
        wait_idle("t4_busy_low", 20, 1'b1);
        set_dl(1'b1);
        @(posedge clk);
        #1;
        check("t4_ovf_clear", overflow, 0);
        check("t4_busy_again", dwnld_busy, 1);

        // Even-only bytes: each pushed by its successor, the last on flush
        expect_write(2'd0, 23'h0, 16'h5151, 2'b10);
        expect_write(2'd0, 23'h1, 16'h5252, 2'b10);
        expect_write(2'd0, 23'h2, 16'h5353, 2'b10);
        send_byte(25'h0, 8'h51);
        send_byte(25'h2, 8'h52);
        send_byte(25'h4, 8'h53);
        set_dl(1'b0);
        wait_idle("t5_drain", 80, 1'b1);

        // Reset in the middle of a stalled download discards everything
        set_dl(1'b1);
        rdy_en = 1'b0;
        expect_write(2'd0, 23'h8, 16'h6160, 2'b00);
        for (int i = 0; i < 12; i++) send_byte(25'h10 + 25'(i), 8'h60 + 8'(i));
        send_byte(25'h1C, 8'h70);
        @(posedge clk);
        #1;
        check("t6_ovf_before_rst", overflow, 1);
        check("t6_we_before_rst", prog_we, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        downloading = 1'b0;
        hold_vld_m = 1'b0;
        #1;
        check("t6_rst_async_we", prog_we, 0);
        check("t6_rst_async_busy", dwnld_busy, 0);
        check("t6_rst_async_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        rdy_en = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("t6_no_pending", exp_q.size(), 0);
        check("t6_we_after", prog_we, 0);
        check("t6_busy_after", dwnld_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtframe_ioctl_pack.md
Name: jtframe_ioctl_pack

Overview:
- Sits directly downstream of the MiST/MiSTer base's SPI ROM loader; consumes the byte stream ioctl_addr/ioctl_dout/ioctl_wr.
- Maps each byte to an SDRAM bank and word address, and merges adjacent even/odd bytes into one 16-bit write.
- Buffers writes in a small FIFO and drives the board's prog_* write handshake.
- Produces dwnld_busy, which the board uses as its download/reset-hold signal.

Parameters:
- SDRAMW, 23, SDRAM word-address width.
- BA1_START, 25'h10_0000, first download byte address mapped to bank 1.
- BA2_START, 25'h20_0000, first byte address mapped to bank 2.
- BA3_START, 25'h30_0000, first byte address mapped to bank 3.
- FIFO_AW, 2, FIFO address width (depth 2**FIFO_AW entries).

Ports:
- clk  in  1  system/ROM clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- downloading  in  1  loader download window.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wr  in  1  one-cycle byte strobe.
- prog_addr  out  SDRAMW  word address within the bank.
- prog_data  out  16  write data.
- prog_mask  out  2  byte mask, active low ([0]=low byte).
- prog_ba  out  2  SDRAM bank.
- prog_we  out  1  write request.
- prog_rdy  in  1  one-cycle write-complete pulse.
- dwnld_busy  out  1  download still in progress.
- overflow  out  1  sticky: a byte was dropped.

Behaviour:
- Reset values: all outputs 0; hold register empty; FIFO empty; FSM in IDLE.
- Bank map (combinational per byte):
  - addr>=BA3_START -> bank 3, else addr>=BA2_START -> bank 2, else addr>=BA1_START -> bank 1, else bank 0.
  - off = addr - bank start.
  - word = off[SDRAMW:1]; lane = off[0].
- Data is always duplicated on both halves: data = {byte,byte}.
  - Even lane: mask 2'b10.
  - Odd lane: mask 2'b01.
  - Merged even+odd pair: mask 2'b00, data = {odd,even}.
- Hold register: one pending even byte (bank, word, byte). Per ioctl_wr, with at most one FIFO push per cycle:
  - Odd byte, hold valid, same bank and word -> push merged word; clear hold.
  - Odd byte, otherwise -> push the held entry if present, else push the odd byte alone (mask 01).
    - In the held-push case the odd byte is lost; the loader contract forbids this case. The bench flags it via an assertion only.
  - Even byte, hold empty -> load hold; no push.
  - Even byte, hold valid -> push held entry; load hold with the new byte.
- Flush: on the falling edge of downloading, a valid hold is pushed as single byte (mask 10). ioctl_wr never coincides with that edge.
- FIFO full at a push -> entry dropped, overflow <= 1. overflow clears on the rising edge of downloading.
- SDRAM-side FSM:
  - IDLE: if FIFO not empty, pop; register addr/data/mask/ba; prog_we <= 1; go to WAIT.
  - WAIT: hold prog_we and all prog_* stable until prog_rdy. On prog_rdy: prog_we <= 0; go to IDLE.
  - Minimum one idle cycle between requests.
  - prog_rdy in IDLE is ignored.
- Latency: push in cycle N -> prog_we high in cycle N+1 when the FSM is idle and the FIFO was empty. A merged pair therefore raises prog_we 2 cycles after the odd ioctl_wr.
- dwnld_busy:
  - Set on the rising edge of downloading.
  - Cleared on the first cycle where downloading=0, hold empty, FIFO empty and FSM in IDLE.
- Reset mid-download: everything returns to reset values immediately; pending data is discarded.

Decomposition:
- Shared package jtframe_dwnld_pkg: bank-start defaults, mask constants (MASK_LO=2'b10, MASK_HI=2'b01, MASK_W=2'b00), packed FIFO entry typedef {ba, addr, data, mask}.
- One sub-module: jtframe_ioctl_fifo (synchronous single-clock FIFO; push/pop/full/empty, registered storage).

Test Plan:
- Bytes 0x12@0, 0x34@1, prog_rdy 3 cycles after each request -> one write: addr 0, data 16'h3412, mask 00, ba 0. prog_we rises 2 cycles after the second byte.
- Byte 0xAA@0x5, downloading falls -> one write: addr 2, data 16'hAAAA, mask 01. dwnld_busy drops the cycle after prog_rdy.
- Bytes 0x11@0x0FFFFE, 0x22@0x0FFFFF, 0x33@BA1_START -> ba 0 addr 0x7FFFF data 2211 mask 00, then ba 1 addr 0 data 3333 mask 10 (after flush).
- prog_rdy withheld while 12 consecutive bytes arrive -> 4 entries queued, overflow=1. Exactly the first 4 words appear once prog_rdy resumes. overflow clears on the next downloading rise.
- Even-only bytes @0,2,4 -> three mask-10 writes at addr 0,1,2 (each pushed when the next arrives, last on flush).
- rst pulsed while in WAIT with FIFO non-empty -> prog_we=0, dwnld_busy=0, overflow=0 asynchronously. No further writes.
